// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: two-channel round-robin arbiter feeding one registered
// output stage through a shared N-bit 2:1 mux. Each channel gets a
// saturating count of the words it has had accepted.
module rr_mux_arbiter #(
   parameter int N     = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             a_valid,
   input  logic [N-1:0]     a_data,
   output logic             a_ready,
   input  logic             b_valid,
   input  logic [N-1:0]     b_data,
   output logic             b_ready,
   output logic             out_valid,
   output logic [N-1:0]     out_data,
   output logic             out_src,
   input  logic             out_ready,
   output logic             sel,
   output logic [CNT_W-1:0] a_cnt,
   output logic [CNT_W-1:0] b_cnt
);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   state_t         state;
   state_t         state_next;
   logic           last_src;
   logic           grant_a;
   logic           grant_b;
   logic           can_load;
   logic           accept;
   logic [N-1:0]   mux_data;

   // Increment that sticks at the all-ones value instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      logic [CNT_W-1:0] one;
      one = {{(CNT_W-1){1'b0}}, 1'b1};
      return (&v) ? v : v + one;
   endfunction

   // Arbitration, ready generation and next-state decision.
   always_comb begin
      grant_a    = 1'b0;
      grant_b    = 1'b0;
      sel        = 1'b0;
      can_load   = 1'b0;
      a_ready    = 1'b0;
      b_ready    = 1'b0;
      accept     = 1'b0;
      state_next = state;

      // Under contention the channel that did not win the last accepted
      // transfer gets the grant; otherwise whoever is valid wins.
      if (a_valid && b_valid) begin
         grant_a = ~last_src;
         grant_b = last_src;
      end else begin
         grant_a = a_valid;
         grant_b = b_valid;
      end
      sel = grant_a;

      // While FULL the register can be reloaded only if it drains this cycle.
      can_load = (state == EMPTY) || out_ready;
      a_ready  = grant_a && can_load;
      b_ready  = grant_b && can_load;
      accept   = a_ready || b_ready;

      case (state)
         EMPTY: begin
            if (accept) state_next = FULL;
         end
         FULL: begin
            if (accept)         state_next = FULL;
            else if (out_ready) state_next = EMPTY;
         end
         default: state_next = EMPTY;
      endcase
   end

   assign out_valid = (state == FULL);
   assign mux_data  = sel ? a_data : b_data;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= EMPTY;
      else        state <= state_next;
   end

   // Output word, source tag, round-robin pointer and transfer counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data <= '0;
         out_src  <= 1'b0;
         last_src <= 1'b0;
         a_cnt    <= '0;
         b_cnt    <= '0;
      end else if (accept) begin
         out_data <= mux_data;
         out_src  <= sel;
         last_src <= sel;
         if (sel) a_cnt <= sat_inc(a_cnt);
         else     b_cnt <= sat_inc(b_cnt);
      end
   end

endmodule

// File: doc/rr_mux_arbiter.md
# rr_mux_arbiter

Two-requester round-robin arbiter that shares one N-bit 2-to-1 selection path and a one-entry output register between channels A and B. It picks a winner each cycle, drives the select line of the N-bit 2:1 mux, and captures the selected word into a registered output stage with valid/ready handshakes on every side. The block sits in front of shared register and datapath resources as the standard way to merge two producers into one consumer.

## Interface
- N, 8, data width of both inputs and the output
- CNT_W, 16, width of the per-channel saturating grant counters
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- a_valid  in  1  channel A has a word
- a_data  in  N  channel A word
- a_ready  out  1  channel A word accepted this cycle when high with a_valid
- b_valid  in  1  channel B has a word
- b_data  in  N  channel B word
- b_ready  out  1  channel B word accepted this cycle when high with b_valid
- out_valid  out  1  output register holds a word
- out_data  out  N  registered word
- out_src  out  1  source of out_data: 1 = A, 0 = B
- out_ready  in  1  consumer takes the word when high with out_valid
- sel  out  1  mux select, combinational: 1 = A, 0 = B
- a_cnt  out  CNT_W  accepted A transfers, saturating
- b_cnt  out  CNT_W  accepted B transfers, saturating

## Operation
- One clock; reset is asynchronous and active-low on rst_n.
- States: EMPTY (out_valid=0) and FULL (out_valid=1).
- can_load = (state==EMPTY) | (out_ready & out_valid).
- Arbitration, evaluated combinationally every cycle:
  - only a_valid set: grant A; only b_valid set: grant B.
  - both set: grant the channel opposite last_src.
  - neither set: no grant, sel = 0.
- sel = 1 when A is granted, else 0. The internal N-bit 2:1 mux uses sel=1 for a_data and sel=0 for b_data.
- a_ready = grant_A & can_load. b_ready = grant_B & can_load. At most one ready is high in any cycle.
- Accept occurs when the granted channel's valid and ready are both high. On accept:
  - out_data <= mux output; out_src <= sel; last_src <= sel.
  - That channel's counter increments and saturates at 2^CNT_W-1.
  - State becomes FULL.
- Drain without accept (out_valid & out_ready, no grant): EMPTY.
- Drain and accept in the same cycle: stay FULL and load the new word.
- FULL with out_ready=0: hold out_data/out_src stable and force both readys low. Arbitration is still computed and sel still reflects it, but last_src does not change.
- last_src updates only on accept, never on a grant without accept.
- Input valid/data are not required to be stable while unaccepted. The arbiter re-evaluates every cycle.

## Timing
- Reset values: out_valid=0, out_data=0, out_src=0, last_src=0 (B), a_cnt=0, b_cnt=0, state EMPTY. a_ready, b_ready and sel then follow from inputs (0 when no valid).
- Latency: 1 cycle. A word accepted at edge k appears on out_data with out_valid=1 after edge k.
- Throughput: 1 word/cycle while out_ready stays high.
- With both channels continuously valid and out_ready=1, grants alternate A,B,A,B…. A wins first after reset because last_src resets to B.
- Ready paths are combinational from valid and out_ready. There is no combinational path from data inputs to control outputs.
- Reset asserted mid-operation clears the buffered word immediately (out_valid falls asynchronously). Counters clear. The first post-reset grant under contention goes to A.
- Counter saturation: at 2^CNT_W-1 the counter holds. Transfers still complete normally.

## Test plan
- Reset, then a_valid=1, a_data=8'h3C, b_valid=0, out_ready=1 for one cycle -> a_ready=1, sel=1; next cycle out_valid=1, out_data=8'h3C, out_src=1, a_cnt=1.
- Both valid for 6 cycles (A=8'hA0+i, B=8'hB0+i, both held until accepted), out_ready=1 -> outputs A0,B0,A1,B1,A2,B2 back-to-back. Final a_cnt=3, b_cnt=3.
- Load 8'h55 from B, then hold out_ready=0 for 4 cycles with a_valid=1 -> out_data stays 8'h55, out_src=0, a_ready=0 throughout. On out_ready=1, A's word loads in that same cycle and out_valid stays 1.
- FULL with out_ready=1 and no input valid -> next cycle out_valid=0, sel=0. last_src is unchanged, verified by contention going to the opposite channel next.
- Assert rst_n=0 asynchronously mid-cycle while FULL with 8'hFF -> out_valid, out_data and counters are 0 before the next clock edge. After release, both valid -> A granted first.
- CNT_W=2, 5 accepted A transfers -> a_cnt goes 1,2,3,3,3 and all 5 words are delivered.
